// File: rtl/regfile_arb_pkg.sv
// regfile_arb_pkg
//   Shared types and constants for the register-file write arbiter and its
//   round-robin picker.
//   Contents:
//     arb_state_t       : arbiter FSM states (ARB, LOCKED)
//     BUS_WIDTH         : datapath bus width; write data is one bit wider
//     write_beat_t      : one write beat {address, data, source}
//     onehot_to_index() : encodes a one-hot grant vector into a source index
package regfile_arb_pkg;

    localparam int NUMBER_OF_REQUESTERS = 3;
    localparam int NUMBER_OF_REGISTERS  = 16;
    localparam int BUS_WIDTH            = 7;
    localparam int DATA_WIDTH           = BUS_WIDTH + 1;
    localparam int MAX_LOCK_BEATS       = 8;
    localparam int ADDR_WIDTH           = $clog2(NUMBER_OF_REGISTERS);
    localparam int SOURCE_WIDTH         = $clog2(NUMBER_OF_REQUESTERS);
    localparam int COUNT_WIDTH          = $clog2(MAX_LOCK_BEATS + 1);
    localparam int PERF_WIDTH           = 16;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]          address;
        logic signed [DATA_WIDTH-1:0]   data;
        logic [SOURCE_WIDTH-1:0]        source;
    } write_beat_t;

    // OR-reduction encoder: valid for one-hot or all-zero input.
    function automatic logic [SOURCE_WIDTH-1:0] onehot_to_index(
        input logic [NUMBER_OF_REQUESTERS-1:0] oneHot
    );
        logic [SOURCE_WIDTH-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUMBER_OF_REQUESTERS; i++) begin
            if (oneHot[i]) begin
                idx = idx | SOURCE_WIDTH'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker
//   Combinational round-robin pick: returns a one-hot vector selecting the
//   first set request bit at or above the pointer, wrapping from N-1 to 0.
//   Ports:
//     i_request [N]  : request bits
//     i_pointer [PW] : highest-priority index this cycle (must be < N)
//     o_grant   [N]  : one-hot pick, all zero when no request is set
module rr_priority_picker #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_request,
    input  logic [PW-1:0] i_pointer,
    output logic [N-1:0]  o_grant
);

    int   w_idx;
    logic w_found;

    // Walk the N positions starting at the pointer; the first request seen wins.
    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < N; k++) begin
            w_idx = int'(i_pointer) + k;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            if (!w_found && i_request[PW'(w_idx)]) begin
                o_grant[PW'(w_idx)] = 1'b1;
                w_found             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the single register-file write port between N writeback sources
//   using round-robin arbitration with an optional burst lock, and drives the
//   write port from one registered output stage (accept in t -> write in t+1).
//   Optional feature macro: REGFILE_ARB_PERF_EN adds per-source saturating
//   accepted-beat counters on grant_count_out.
//   Ports:
//     clock_in, reset_in          : clock, synchronous active-high reset
//     request_valid_in   [N]      : source has a beat pending
//     request_lock_in    [N]      : source wants to keep the grant after this beat
//     request_address_in [N*A]    : packed destination register per source
//     request_data_in    [N*DW]   : packed signed write data per source
//     request_ready_out  [N]      : one-hot grant (beat accepted on valid&ready)
//     write_stall_in              : register file busy, freeze everything
//     write_enable_out, write_register_address_out, write_data_out,
//     write_source_out            : registered register-file write port
//     dropped_write_out           : accepted beat targeted register 0
//     grant_count_out    [N*16]   : (REGFILE_ARB_PERF_EN only) accepted-beat counts
module regfile_write_arbiter
    import regfile_arb_pkg::*;
(
    input  logic                                      clock_in,
    input  logic                                      reset_in,
    input  logic [NUMBER_OF_REQUESTERS-1:0]           request_valid_in,
    input  logic [NUMBER_OF_REQUESTERS-1:0]           request_lock_in,
    input  logic [NUMBER_OF_REQUESTERS*ADDR_WIDTH-1:0] request_address_in,
    input  logic [NUMBER_OF_REQUESTERS*DATA_WIDTH-1:0] request_data_in,
    output logic [NUMBER_OF_REQUESTERS-1:0]           request_ready_out,
    input  logic                                      write_stall_in,
    output logic                                      write_enable_out,
    output logic [ADDR_WIDTH-1:0]                     write_register_address_out,
    output logic [DATA_WIDTH-1:0]                     write_data_out,
    output logic [SOURCE_WIDTH-1:0]                   write_source_out,
    output logic                                      dropped_write_out
`ifdef REGFILE_ARB_PERF_EN
    ,
    output logic [NUMBER_OF_REQUESTERS*PERF_WIDTH-1:0] grant_count_out
`endif
);

    arb_state_t                      r_state, w_nextState;
    logic [SOURCE_WIDTH-1:0]         r_rrPointer, w_nextPointer;
    logic [SOURCE_WIDTH-1:0]         r_owner, w_nextOwner;
    logic [COUNT_WIDTH-1:0]          r_lockCount, w_nextLockCount;
    logic [NUMBER_OF_REQUESTERS-1:0] w_ownerMask;
    logic [NUMBER_OF_REQUESTERS-1:0] w_eligible;
    logic [NUMBER_OF_REQUESTERS-1:0] w_pick;
    logic [SOURCE_WIDTH-1:0]         w_grantIdx;
    logic                            w_accept;
    write_beat_t                     w_beat;
    write_beat_t                     r_outBeat;
    logic                            r_writeEnable;
    logic                            r_dropped;

    // While locked only the owner is eligible, so the picker result is the
    // owner (if valid) regardless of where the pointer sits.
    always_comb begin
        w_ownerMask          = '0;
        w_ownerMask[r_owner] = 1'b1;
        w_eligible           = (r_state == LOCKED) ? (request_valid_in & w_ownerMask)
                                                   : request_valid_in;
    end

    rr_priority_picker #(
        .N (NUMBER_OF_REQUESTERS),
        .PW(SOURCE_WIDTH)
    ) u_picker (
        .i_request(w_eligible),
        .i_pointer(r_rrPointer),
        .o_grant  (w_pick)
    );

    // Ready is suppressed during stall and reset so no beat can slip through.
    always_comb begin
        request_ready_out = w_pick;
        if (reset_in || write_stall_in) begin
            request_ready_out = '0;
        end
    end

    // The picker only selects valid sources, so any ready bit is an accept.
    always_comb begin
        w_accept   = |request_ready_out;
        w_grantIdx = onehot_to_index(request_ready_out);
        w_beat     = '0;
        for (int i = 0; i < NUMBER_OF_REQUESTERS; i++) begin
            if (request_ready_out[i]) begin
                w_beat.address = request_address_in[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_beat.data    = request_data_in[i*DATA_WIDTH +: DATA_WIDTH];
                w_beat.source  = SOURCE_WIDTH'(i);
            end
        end
    end

    // Next-state logic. The pointer only moves on grants made in ARB, so after
    // a burst it already points one past the former owner.
    always_comb begin
        w_nextState     = r_state;
        w_nextPointer   = r_rrPointer;
        w_nextOwner     = r_owner;
        w_nextLockCount = r_lockCount;
        if (w_accept) begin
            case (r_state)
                ARB: begin
                    w_nextPointer = (w_grantIdx == SOURCE_WIDTH'(NUMBER_OF_REQUESTERS - 1))
                                  ? '0 : (w_grantIdx + SOURCE_WIDTH'(1));
                    if (request_lock_in[w_grantIdx]) begin
                        w_nextState     = LOCKED;
                        w_nextOwner     = w_grantIdx;
                        w_nextLockCount = COUNT_WIDTH'(1);
                    end
                end
                LOCKED: begin
                    // Beat-count limit forces release even with lock still held.
                    if (!request_lock_in[r_owner] ||
                        (r_lockCount == COUNT_WIDTH'(MAX_LOCK_BEATS - 1))) begin
                        w_nextState     = ARB;
                        w_nextLockCount = '0;
                    end else begin
                        w_nextLockCount = r_lockCount + COUNT_WIDTH'(1);
                    end
                end
                default: w_nextState = ARB;
            endcase
        end
    end

    // State, pointer and lock tracking; frozen while the register file stalls.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            r_state     <= ARB;
            r_rrPointer <= '0;
            r_owner     <= '0;
            r_lockCount <= '0;
        end else if (!write_stall_in) begin
            r_state     <= w_nextState;
            r_rrPointer <= w_nextPointer;
            r_owner     <= w_nextOwner;
            r_lockCount <= w_nextLockCount;
        end
    end

    // Output stage reloads every unstalled cycle; a register-0 target is
    // accepted but turned into a drop pulse instead of a write.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            r_outBeat     <= '0;
            r_writeEnable <= 1'b0;
            r_dropped     <= 1'b0;
        end else if (!write_stall_in) begin
            r_writeEnable <= w_accept && (w_beat.address != '0);
            r_dropped     <= w_accept && (w_beat.address == '0);
            if (w_accept) begin
                r_outBeat <= w_beat;
            end
        end
    end

    assign write_enable_out           = r_writeEnable;
    assign write_register_address_out = r_outBeat.address;
    assign write_data_out             = r_outBeat.data;
    assign write_source_out           = r_outBeat.source;
    assign dropped_write_out          = r_dropped;

`ifdef REGFILE_ARB_PERF_EN
    logic [PERF_WIDTH-1:0] r_grantCount [NUMBER_OF_REQUESTERS];

    // Per-source accepted-beat counters, saturating at all ones.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            for (int i = 0; i < NUMBER_OF_REQUESTERS; i++) begin
                r_grantCount[i] <= '0;
            end
        end else if (!write_stall_in) begin
            for (int i = 0; i < NUMBER_OF_REQUESTERS; i++) begin
                if (request_ready_out[i] && (r_grantCount[i] != '1)) begin
                    r_grantCount[i] <= r_grantCount[i] + PERF_WIDTH'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < NUMBER_OF_REQUESTERS; g++) begin : g_perfPack
        assign grant_count_out[g*PERF_WIDTH +: PERF_WIDTH] = r_grantCount[g];
    end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter
//   Table-driven bench for regfile_write_arbiter: each record holds one
//   cycle of inputs, the expected combinational ready, and the expected
//   registered write port one clock later. Stall and reset-mid-lock corner
//   cases are written out as explicit record sequences.
module tb_regfile_write_arbiter;

    typedef struct {
        logic        rst;
        logic        stall;
        logic [2:0]  valid;
        logic [2:0]  lock;
        logic [11:0] addr;
        logic [23:0] data;
        logic [2:0]  expRdy;
        logic        expWe;
        logic [3:0]  expAddr;
        logic [7:0]  expData;
        logic [1:0]  expSrc;
        logic        expDrop;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [2:0]  valid;
    logic [2:0]  lock;
    logic [11:0] addr;
    logic [23:0] data;
    logic [2:0]  ready;
    logic        we;
    logic [3:0]  wAddr;
    logic [7:0]  wData;
    logic [1:0]  wSrc;
    logic        dropped;
`ifdef REGFILE_ARB_PERF_EN
    logic [47:0] grantCount;
`endif

    int vecCount  = 0;
    int compCount = 0;
    int missCount = 0;
    int modelCount [3];
    vec_t vecs [$];

    localparam logic [11:0] A123 = {4'd3, 4'd2, 4'd1};
    localparam logic [23:0] D123 = {8'd30, 8'hEC, 8'd10};

    always #5 clk = ~clk;

    regfile_write_arbiter dut (
`ifdef REGFILE_ARB_PERF_EN
        .grant_count_out           (grantCount),
`endif
        .clock_in                  (clk),
        .reset_in                  (rst),
        .request_valid_in          (valid),
        .request_lock_in           (lock),
        .request_address_in        (addr),
        .request_data_in           (data),
        .request_ready_out         (ready),
        .write_stall_in            (stall),
        .write_enable_out          (we),
        .write_register_address_out(wAddr),
        .write_data_out            (wData),
        .write_source_out          (wSrc),
        .dropped_write_out         (dropped)
    );

    function automatic vec_t mk(
        input logic rs, input logic st, input logic [2:0] v, input logic [2:0] lk,
        input logic [11:0] a, input logic [23:0] d, input logic [2:0] er,
        input logic ew, input logic [3:0] ea, input logic [7:0] ed,
        input logic [1:0] es, input logic edr
    );
        vec_t r;
        r.rst = rs; r.stall = st; r.valid = v; r.lock = lk; r.addr = a; r.data = d;
        r.expRdy = er; r.expWe = ew; r.expAddr = ea; r.expData = ed;
        r.expSrc = es; r.expDrop = edr;
        return r;
    endfunction

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        compCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s (vector %0d): got %0h, expected %0h", name, vecCount, act, exp);
        end
    endtask

    // Drive one record at the falling edge and check the combinational ready.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rst = v.rst; stall = v.stall; valid = v.valid; lock = v.lock;
        addr = v.addr; data = v.data;
        #1;
        compare("ready", 32'(ready), 32'(v.expRdy));
    endtask

    // After the rising edge, check the registered write port against the record.
    task automatic checkOutput(input vec_t v);
        @(posedge clk);
        #1;
        if (v.rst) begin
            for (int i = 0; i < 3; i++) modelCount[i] = 0;
        end else if (!v.stall) begin
            for (int i = 0; i < 3; i++) if (v.expRdy[i]) modelCount[i]++;
        end
        compare("write_enable", 32'(we), 32'(v.expWe));
        compare("dropped", 32'(dropped), 32'(v.expDrop));
        if (v.expWe) begin
            compare("write_addr", 32'(wAddr), 32'(v.expAddr));
            compare("write_data", 32'(wData), 32'(v.expData));
        end
        if (v.expWe || v.expDrop) begin
            compare("write_source", 32'(wSrc), 32'(v.expSrc));
        end
`ifdef REGFILE_ARB_PERF_EN
        for (int i = 0; i < 3; i++) begin
            compare("grant_count", 32'(grantCount[i*16 +: 16]), 32'(modelCount[i]));
        end
`endif
        vecCount++;
    endtask

    task automatic runVec(input vec_t v);
        applyStimulus(v);
        checkOutput(v);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; valid = '0; lock = '0; addr = '0; data = '0;
        for (int i = 0; i < 3; i++) modelCount[i] = 0;

        // Reset with valids high, then round-robin over all three sources.
        vecs.push_back(mk(1, 0, 3'b111, 3'b000, A123, D123, 3'b000, 0, 0, 0,     0, 0));
        vecs.push_back(mk(1, 0, 3'b111, 3'b000, A123, D123, 3'b000, 0, 0, 0,     0, 0));
        vecs.push_back(mk(0, 0, 3'b111, 3'b000, A123, D123, 3'b001, 1, 1, 8'd10, 0, 0));
        vecs.push_back(mk(0, 0, 3'b111, 3'b000, A123, D123, 3'b010, 1, 2, 8'hEC, 1, 0));
        vecs.push_back(mk(0, 0, 3'b111, 3'b000, A123, D123, 3'b100, 1, 3, 8'd30, 2, 0));
        vecs.push_back(mk(0, 0, 3'b000, 3'b000, A123, D123, 3'b000, 0, 0, 0,     0, 0));
        // Source 1 targets register 0: accepted but dropped, pointer moves to 2.
        vecs.push_back(mk(0, 0, 3'b010, 3'b000, {4'd3, 4'd0, 4'd1}, {8'd30, 8'd55, 8'd10},
                          3'b010, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 3'b000, 3'b000, A123, D123, 3'b000, 0, 0, 0,     0, 0));
        vecs.push_back(mk(0, 0, 3'b111, 3'b000, A123, D123, 3'b100, 1, 3, 8'd30, 2, 0));
        vecs.push_back(mk(0, 0, 3'b001, 3'b000, A123, D123, 3'b001, 1, 1, 8'd10, 0, 0));
        vecs.push_back(mk(0, 0, 3'b010, 3'b000, A123, D123, 3'b010, 1, 2, 8'hEC, 1, 0));
        // Source 2 locks while source 0 waits: 8 beats, then source 0, then source 2.
        for (int b = 0; b < 8; b++) begin
            vecs.push_back(mk(0, 0, 3'b101, 3'b100, A123, {8'(40 + b), 8'hEC, 8'd10},
                              3'b100, 1, 3, 8'(40 + b), 2, 0));
        end
        vecs.push_back(mk(0, 0, 3'b101, 3'b100, A123, {8'd48, 8'hEC, 8'd10}, 3'b001, 1, 1, 8'd10, 0, 0));
        vecs.push_back(mk(0, 0, 3'b101, 3'b100, A123, {8'd48, 8'hEC, 8'd10}, 3'b100, 1, 3, 8'd48, 2, 0));
        vecs.push_back(mk(0, 0, 3'b101, 3'b100, A123, {8'd49, 8'hEC, 8'd10}, 3'b100, 1, 3, 8'd49, 2, 0));
        vecs.push_back(mk(0, 0, 3'b101, 3'b100, A123, {8'd50, 8'hEC, 8'd10}, 3'b100, 1, 3, 8'd50, 2, 0));
        vecs.push_back(mk(0, 0, 3'b101, 3'b000, A123, {8'd51, 8'hEC, 8'd10}, 3'b100, 1, 3, 8'd51, 2, 0));
        vecs.push_back(mk(0, 0, 3'b101, 3'b000, A123, D123, 3'b001, 1, 1, 8'd10, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            runVec(vecs[i]);
        end

        // Stall for three cycles mid-stream: ready drops, port holds, no beat lost.
        runVec(mk(0, 0, 3'b111, 3'b000, A123, D123, 3'b010, 1, 2, 8'hEC, 1, 0));
        for (int s = 0; s < 3; s++) begin
            runVec(mk(0, 1, 3'b111, 3'b000, A123, D123, 3'b000, 1, 2, 8'hEC, 1, 0));
        end
        runVec(mk(0, 0, 3'b111, 3'b000, A123, D123, 3'b100, 1, 3, 8'd30, 2, 0));
        runVec(mk(0, 0, 3'b111, 3'b000, A123, D123, 3'b001, 1, 1, 8'd10, 0, 0));

        // Source 2 locks; an owner bubble blocks source 0; reset at beat 4 abandons the lock.
        runVec(mk(0, 0, 3'b100, 3'b100, A123, D123, 3'b100, 1, 3, 8'd30, 2, 0));
        runVec(mk(0, 0, 3'b100, 3'b100, A123, D123, 3'b100, 1, 3, 8'd30, 2, 0));
        runVec(mk(0, 0, 3'b001, 3'b000, A123, D123, 3'b000, 0, 0, 0,     0, 0));
        runVec(mk(0, 0, 3'b101, 3'b100, A123, D123, 3'b100, 1, 3, 8'd30, 2, 0));
        runVec(mk(0, 0, 3'b101, 3'b100, A123, D123, 3'b100, 1, 3, 8'd30, 2, 0));
        runVec(mk(1, 0, 3'b101, 3'b100, A123, D123, 3'b000, 0, 0, 0,     0, 0));
        runVec(mk(0, 0, 3'b101, 3'b100, A123, D123, 3'b001, 1, 1, 8'd10, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
